// File: rtl/cm0_dap_cdc_recv_handshake_pkg.sv
// Shared definitions for the DAP CDC receive handshake: FSM encoding and
// synchroniser depth limits.
package cm0_dap_cdc_recv_handshake_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        ACKH = 2'b10
    } recv_state_e;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;

    // Out-of-range depths are pulled back into the supported window.
    function automatic int unsigned sync_stages_clamp(input int unsigned n);
        if (n < SYNC_STAGES_MIN) return SYNC_STAGES_MIN;
        if (n > SYNC_STAGES_MAX) return SYNC_STAGES_MAX;
        return n;
    endfunction

endpackage

// File: rtl/cm0_dap_cdc_sync.sv
// Flop chain with synchronous active-low reset. Used both as the REQ
// synchroniser and, at depth 1, as the dedicated ACK launch flop.
module cm0_dap_cdc_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ff <= '0;
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                ff[i] <= ff[i-1];
            end
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/cm0_dap_cdc_recv_handshake.sv
// Receive end of the DAP four-phase CDC handshake: synchronises REQ, captures
// the crossing word, offers it on valid/ready and returns ACK from a flop.
module cm0_dap_cdc_recv_handshake
    import cm0_dap_cdc_recv_handshake_pkg::*;
#(
    parameter int unsigned DW          = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          PRESENT     = 1'b1
) (
    input  logic          REGCLK,
    input  logic          REGRESETn,
    input  logic          REQ_ASYNC,
    input  logic [DW-1:0] DATA_ASYNC,
    input  logic          RREADY,
    output logic          RVALID,
    output logic [DW-1:0] RDATA,
    output logic          ACK,
    output logic          PROTERR
);

    if (PRESENT) begin : g_present
        localparam int unsigned NSYNC = sync_stages_clamp(SYNC_STAGES);

        logic          req_s;
        recv_state_e   state;
        logic          rvalid_q;
        logic [DW-1:0] rdata_q;
        logic          proterr_q;
        logic          ack_d;
        logic          ack_q;

        cm0_dap_cdc_sync #(.STAGES(NSYNC)) u_req_sync (
            .clk  (REGCLK),
            .rstn (REGRESETn),
            .d    (REQ_ASYNC),
            .q    (req_s)
        );

        // ACK leaves the domain straight from this flop's Q, so its D is
        // derived from the state transition rather than decoded afterwards.
        cm0_dap_cdc_sync #(.STAGES(1)) u_ack_ff (
            .clk  (REGCLK),
            .rstn (REGRESETn),
            .d    (ack_d),
            .q    (ack_q)
        );

        always_comb begin
            ack_d = ack_q;
            case (state)
                IDLE:    ack_d = 1'b0;
                HOLD:    if (RREADY) ack_d = 1'b1;
                ACKH:    if (!req_s) ack_d = 1'b0;
                default: ack_d = 1'b0;
            endcase
        end

        always_ff @(posedge REGCLK) begin
            if (!REGRESETn) begin
                state     <= IDLE;
                rvalid_q  <= 1'b0;
                rdata_q   <= '0;
                proterr_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (req_s) begin
                            rdata_q  <= DATA_ASYNC;
                            rvalid_q <= 1'b1;
                            state    <= HOLD;
                        end
                    end
                    HOLD: begin
                        // Sender withdrew before delivery; still finish the word.
                        if (!req_s) proterr_q <= 1'b1;
                        if (RREADY) begin
                            rvalid_q <= 1'b0;
                            state    <= ACKH;
                        end
                    end
                    ACKH: begin
                        if (!req_s) state <= IDLE;
                    end
                    default: begin
                        rvalid_q <= 1'b0;
                        state    <= IDLE;
                    end
                endcase
            end
        end

        assign RVALID  = rvalid_q;
        assign RDATA   = rdata_q;
        assign ACK     = ack_q;
        assign PROTERR = proterr_q;

`ifdef ARM_ASSERT_ON
        a_req_known : assert property (@(posedge REGCLK) disable iff (!REGRESETn)
            !$isunknown(req_s));
        a_rready_known : assert property (@(posedge REGCLK) disable iff (!REGRESETn)
            rvalid_q |-> !$isunknown(RREADY));
        a_ack_req_low : assert property (@(posedge REGCLK) disable iff (!REGRESETn)
            (ack_q && !req_s) |-> (state == ACKH));
`endif
    end else begin : g_absent
        logic unused_inputs;
        assign unused_inputs = ^{REGCLK, REGRESETn, REQ_ASYNC, DATA_ASYNC, RREADY};

        assign RVALID  = 1'b0;
        assign RDATA   = '0;
        assign ACK     = 1'b0;
        assign PROTERR = 1'b0;
    end

endmodule

// File: tb/tb_cm0_dap_cdc_recv_handshake.sv
// Directed bench for the DAP CDC receive handshake, with a second instance
// built with PRESENT=0 sharing the same stimulus.
module tb_cm0_dap_cdc_recv_handshake;

    logic        regclk;
    logic        regresetn;
    logic        req_async;
    logic [31:0] data_async;
    logic        rready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ack;
    logic        proterr;
    logic        p0_rvalid;
    logic [31:0] p0_rdata;
    logic        p0_ack;
    logic        p0_proterr;

    int checks   = 0;
    int failures = 0;

    cm0_dap_cdc_recv_handshake #(.DW(32), .SYNC_STAGES(2), .PRESENT(1'b1)) dut (
        .REGCLK     (regclk),
        .REGRESETn  (regresetn),
        .REQ_ASYNC  (req_async),
        .DATA_ASYNC (data_async),
        .RREADY     (rready),
        .RVALID     (rvalid),
        .RDATA      (rdata),
        .ACK        (ack),
        .PROTERR    (proterr)
    );

    cm0_dap_cdc_recv_handshake #(.DW(32), .SYNC_STAGES(2), .PRESENT(1'b0)) dut_absent (
        .REGCLK     (regclk),
        .REGRESETn  (regresetn),
        .REQ_ASYNC  (req_async),
        .DATA_ASYNC (data_async),
        .RREADY     (rready),
        .RVALID     (p0_rvalid),
        .RDATA      (p0_rdata),
        .ACK        (p0_ack),
        .PROTERR    (p0_proterr)
    );

    initial regclk = 1'b0;
    always #5 regclk = ~regclk;

    task automatic tick();
        @(posedge regclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Data presented to the consumer must match the launched word until ACK rises.
    always @(negedge regclk) begin
        if (regresetn === 1'b1 && rvalid === 1'b1 && ack === 1'b0) begin
            checks++;
            assert (rdata === data_async) else begin
                failures++;
                $error("FAIL data_stable observed=%0h expected=%0h", rdata, data_async);
            end
        end
    end

    initial begin
        int n;
        int hs;

        regresetn  = 1'b0;
        req_async  = 1'b0;
        data_async = 32'h0;
        rready     = 1'b0;
        repeat (3) tick();

        chk("reset_rvalid",  rvalid,  1'b0);
        chk("reset_rdata",   rdata,   32'h0);
        chk("reset_ack",     ack,     1'b0);
        chk("reset_proterr", proterr, 1'b0);
        regresetn = 1'b1;
        tick();

        // Basic transfer with the consumer always ready.
        data_async = 32'hA5A5_0001;
        req_async  = 1'b1;
        rready     = 1'b1;
        tick();
        chk("basic_e1_rvalid", rvalid, 1'b0);
        tick();
        chk("basic_e2_rvalid", rvalid, 1'b0);
        tick();
        chk("basic_e3_rvalid", rvalid, 1'b1);
        chk("basic_e3_rdata",  rdata,  32'hA5A5_0001);
        chk("basic_e3_ack",    ack,    1'b0);
        chk("absent_busy", {p0_rvalid, p0_rdata, p0_ack, p0_proterr}, 64'h0);
        tick();
        chk("basic_e4_rvalid", rvalid, 1'b0);
        chk("basic_e4_ack",    ack,    1'b1);
        req_async = 1'b0;
        tick();
        chk("basic_drop_e1_ack", ack, 1'b1);
        tick();
        chk("basic_drop_e2_ack", ack, 1'b1);
        tick();
        chk("basic_drop_e3_ack", ack, 1'b0);
        chk("basic_proterr", proterr, 1'b0);
        tick();

        // Back-pressure: consumer stalls for 10 cycles.
        rready     = 1'b0;
        data_async = 32'hDEAD_BEEF;
        req_async  = 1'b1;
        repeat (3) tick();
        chk("bp_rvalid", rvalid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold", {rvalid, ack, rdata}, {1'b1, 1'b0, 32'hDEAD_BEEF});
        end
        rready = 1'b1;
        tick();
        chk("bp_release_ack",    ack,    1'b1);
        chk("bp_release_rvalid", rvalid, 1'b0);
        req_async = 1'b0;
        repeat (3) tick();
        chk("bp_ack_low", ack, 1'b0);
        tick();

        // Four back-to-back transfers, sender waits for ACK low each time.
        hs = 0;
        rready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            data_async = k;
            req_async  = 1'b1;
            n = 0;
            while (rvalid !== 1'b1 && n < 12) begin tick(); n++; end
            chk("b2b_rvalid", rvalid, 1'b1);
            chk("b2b_rdata",  rdata,  k);
            if (rvalid === 1'b1 && rready === 1'b1) hs++;
            n = 0;
            while (ack !== 1'b1 && n < 12) begin tick(); n++; end
            chk("b2b_ack_high", ack, 1'b1);
            req_async = 1'b0;
            n = 0;
            while (ack !== 1'b0 && n < 12) begin tick(); n++; end
            chk("b2b_ack_low", ack, 1'b0);
            tick();
        end
        chk("b2b_count",   hs,      4);
        chk("b2b_proterr", proterr, 1'b0);

        // Early REQ drop while the word sits in HOLD.
        rready     = 1'b0;
        data_async = 32'h55AA_1234;
        req_async  = 1'b1;
        repeat (3) tick();
        chk("early_rvalid", rvalid, 1'b1);
        req_async = 1'b0;
        tick();
        tick();
        chk("early_proterr_pre", proterr, 1'b0);
        tick();
        chk("early_proterr", proterr, 1'b1);
        chk("early_still_valid", {rvalid, rdata}, {1'b1, 32'h55AA_1234});
        rready = 1'b1;
        tick();
        chk("early_ack_rise", {rvalid, ack}, {1'b0, 1'b1});
        tick();
        chk("early_ack_fall", ack, 1'b0);
        tick();
        chk("early_proterr_sticky", proterr, 1'b1);

        // Reset while in HOLD.
        rready     = 1'b0;
        data_async = 32'h0BAD_F00D;
        req_async  = 1'b1;
        repeat (3) tick();
        chk("rst_hold_rvalid", rvalid, 1'b1);
        regresetn = 1'b0;
        tick();
        chk("rst_hold_outputs", {rvalid, rdata, ack, proterr}, 64'h0);
        req_async = 1'b0;
        repeat (2) tick();
        regresetn = 1'b1;
        tick();

        // Reset while in ACKH.
        rready     = 1'b1;
        data_async = 32'h1357_9BDF;
        req_async  = 1'b1;
        repeat (3) tick();
        chk("rst_ackh_rvalid", rvalid, 1'b1);
        tick();
        chk("rst_ackh_ack", ack, 1'b1);
        regresetn = 1'b0;
        tick();
        chk("rst_ackh_outputs", {rvalid, rdata, ack, proterr}, 64'h0);
        req_async = 1'b0;
        repeat (2) tick();
        regresetn = 1'b1;
        repeat (2) tick();

        // Transfer after reset recovery.
        data_async = 32'h0000_0077;
        req_async  = 1'b1;
        repeat (3) tick();
        chk("post_rst_rvalid", rvalid, 1'b1);
        chk("post_rst_rdata",  rdata,  32'h0000_0077);
        tick();
        chk("post_rst_ack", ack, 1'b1);
        req_async = 1'b0;
        repeat (3) tick();
        chk("post_rst_ack_low", ack, 1'b0);
        chk("post_rst_proterr", proterr, 1'b0);
        chk("absent_end", {p0_rvalid, p0_rdata, p0_ack, p0_proterr}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cm0_dap_cdc_recv_handshake.md
Name: cm0_dap_cdc_recv_handshake

Overview:
- Receive-side end of the DAP four-phase clock-domain-crossing handshake.
- The sending domain launches a data word and a REQ level from glitch-free CDC send registers. This block synchronises REQ into its own domain, captures the data word, and presents it to a local consumer using a valid/ready handshake.
- It returns ACK to the sender from a dedicated flop.
- It sits on the DP/AP side of the SWJ/DAP domain boundary, one instance per crossing direction.

Parameters:
- DW, 32, width of the crossing data word.
- SYNC_STAGES, 2, number of synchroniser flops on REQ; legal range 2..4.
- PRESENT, 1, when 0 all outputs are tied to 0 and no state is kept.

Ports:
- REGCLK  input  1  receive-domain clock.
- REGRESETn  input  1  synchronous active-low reset, sampled on the REGCLK rising edge.
- REQ_ASYNC  input  1  request level from the sender domain; asynchronous to REGCLK.
- DATA_ASYNC  input  DW  data word from the sender domain; stable while REQ_ASYNC is high.
- RREADY  input  1  local consumer ready.
- RVALID  output  1  captured word valid.
- RDATA  output  DW  captured word.
- ACK  output  1  acknowledge to the sender domain; driven directly from a flop Q, no logic after it.
- PROTERR  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (REGRESETn low at a REGCLK edge): the synchroniser chain, state, RVALID, RDATA, ACK and PROTERR all go to 0. Reset applied mid-transfer abandons the transfer; the sender recovers via its own reset.
- Synchroniser: req_s is REQ_ASYNC passed through SYNC_STAGES flops. Only req_s is used by the control logic.
- FSM states: IDLE, HOLD, ACKH.
- IDLE: when req_s=1, load RDATA<=DATA_ASYNC, set RVALID<=1 and go to HOLD. DATA_ASYNC is sampled only on this edge.
- HOLD: RVALID and RDATA are held constant. When RREADY=1, set RVALID<=0, ACK<=1 and go to ACKH.
- HOLD, sender drops early: if req_s falls in HOLD before the consumer accepts, set PROTERR<=1. Delivery still completes; ACK is then raised, and ACKH exits on the next edge because req_s is already 0.
- ACKH: when req_s=0, set ACK<=0 and go to IDLE.
- Back-to-back requests: a new request cannot be accepted until at least one IDLE cycle after ACK falls. No stale-high req_s is possible, because ACKH waits for a low req_s.
- Latency: REQ_ASYNC rising to RVALID high is SYNC_STAGES+1 REGCLK edges, with up to one extra edge of metastability uncertainty.
- RREADY already high: with RREADY=1 continuously, RVALID is high for exactly 1 cycle and ACK rises on the same edge that RVALID falls.
- ACK timing: ACK changes only on FSM transitions; it never toggles while the state is unchanged (glitch-free requirement).
- PROTERR: cleared only by reset.
- ACK while req_s=0: ACK=1 with req_s=0 occurs only in ACKH.
- Assertions (under ARM_ASSERT_ON):
  - REQ_ASYNC must never be X after synchronisation.
  - RREADY must never be X while RVALID=1.
  - DATA_ASYNC must be stable from the capture edge until ACK rises (bench checker).

Decomposition:
- Shared package: state encoding constants (IDLE=2'b00, HOLD=2'b01, ACKH=2'b10) and the SYNC_STAGES legal-range constants.
- One sub-module: cm0_dap_cdc_sync, a parameterised SYNC_STAGES flop chain with synchronous active-low reset.
- The synchroniser flops and the ACK flop are hand-instantiated cells so synthesis does not restructure them, mirroring the send side.

Test Plan:
- Basic transfer: SYNC_STAGES=2, DATA_ASYNC=32'hA5A5_0001, raise REQ_ASYNC, RREADY=1 -> RVALID high on edge 3 for 1 cycle with RDATA=32'hA5A5_0001; ACK rises on the same edge RVALID falls; drop REQ -> ACK falls 3 edges later.
- Back-pressure: RREADY=0 for 10 cycles after RVALID rises -> RVALID and RDATA held constant for 10 cycles, ACK stays 0; RREADY=1 -> ACK=1 on the next edge.
- Back-to-back transfers: 4 transfers (data 1, 2, 3, 4) with the sender model waiting for ACK low before each REQ -> exactly 4 RVALID handshakes, data in order, PROTERR=0.
- Early REQ drop: REQ falls while in HOLD -> PROTERR=1; the word is still delivered; ACK pulses for 1 cycle and the FSM returns to IDLE.
- Reset mid-transfer: assert REGRESETn=0 in HOLD and in ACKH -> all outputs 0 at the next edge; after release with REQ low the FSM is in IDLE and the next transfer succeeds.
- PRESENT=0: any stimulus -> RVALID, RDATA, ACK and PROTERR remain 0.
